// File: rtl/snn_image_loader.sv
// ============================================================================
// Module   : snn_image_loader
// Purpose  : Unpacks a UART byte stream into 1-bit pixels for the SNN input RAM,
//            then starts snn_core and waits for it to finish.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_image_loader #(
    parameter int NUM_BYTES = 98,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT   = 1000000,
    parameter int TO_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              core_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    output logic              ram_we,
    output logic              ram_owner,
    output logic              core_start,
    output logic [7:0]        frame_cnt,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int C_BC_W = ADDR_W - 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UNPACK    = 3'd1,
        S_RECV      = 3'd2,
        S_START     = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic [2:0]        bit_q, bit_d;
    logic [C_BC_W-1:0] bcnt_q, bcnt_d;
    logic [7:0]        pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              err_to_d, err_ov_d;

    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_wdata_q, ram_we_q, ram_owner_q, core_start_q;
    logic              err_to_q, err_ov_q;

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        bcnt_d   = bcnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        to_d     = to_q;
        fcnt_d   = fcnt_q;
        err_to_d = 1'b0;
        err_ov_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
                bit_d  = 3'd0;
                if (rx_rdy) begin
                    byte_d  = rx_data;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (rx_rdy && pend_v_q) begin
                    err_ov_d = 1'b1;
                end else if (rx_rdy && bit_q != 3'd7) begin
                    pend_d   = rx_data;
                    pend_v_d = 1'b1;
                end
                if (bit_q != 3'd7) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    bit_d = 3'd0;
                    if (bcnt_q == C_BC_W'(NUM_BYTES - 1)) begin
                        // Frame complete: anything queued behind it is lost.
                        state_d  = S_START;
                        bcnt_d   = '0;
                        pend_v_d = 1'b0;
                        if (pend_v_q || rx_rdy) err_ov_d = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                        if (pend_v_q) begin
                            byte_d   = pend_q;
                            pend_v_d = 1'b0;
                        end else if (rx_rdy) begin
                            // Byte arriving on bit 7 chains straight in.
                            byte_d = rx_data;
                        end else begin
                            state_d = S_RECV;
                            to_d    = '0;
                        end
                    end
                end
            end
            S_RECV: begin
                if (rx_rdy) begin
                    byte_d  = rx_data;
                    bit_d   = 3'd0;
                    state_d = S_UNPACK;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    bcnt_d   = '0;
                    state_d  = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_START: begin
                if (rx_rdy) err_ov_d = 1'b1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (rx_rdy) err_ov_d = 1'b1;
                if (core_done) begin
                    fcnt_d  = fcnt_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_q       <= '0;
            bit_q        <= '0;
            bcnt_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            to_q         <= '0;
            fcnt_q       <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_owner_q  <= 1'b0;
            core_start_q <= 1'b0;
            err_to_q     <= 1'b0;
            err_ov_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            bit_q        <= bit_d;
            bcnt_q       <= bcnt_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            to_q         <= to_d;
            fcnt_q       <= fcnt_d;
            ram_we_q     <= (state_d == S_UNPACK);
            ram_owner_q  <= (state_d == S_UNPACK);
            ram_addr_q   <= (state_d == S_UNPACK) ? {bcnt_d, bit_d} : '0;
            ram_wdata_q  <= (state_d == S_UNPACK) & byte_d[bit_d];
            core_start_q <= (state_d == S_START);
            err_to_q     <= err_to_d;
            err_ov_q     <= err_ov_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_we      = ram_we_q;
    assign ram_owner   = ram_owner_q;
    assign core_start  = core_start_q;
    assign frame_cnt   = fcnt_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;

endmodule

`default_nettype wire

// File: doc/snn_image_loader.md
Name: snn_image_loader

Overview:
- Upstream feeder for snn_core. Takes the UART receive byte stream (rx_rdy/rx_data) for one 28x28 binary image, which is 98 bytes or 784 pixels.
- Unpacks each byte into 1-bit pixels and writes them sequentially into the 784x1 input RAM.
- When the frame is complete, pulses core_start and holds off new frames until snn_core reports done.
- Also detects frame timeout and byte overrun.

Parameters:
- NUM_BYTES, 98: bytes per image frame.
- ADDR_W, 10: input RAM address width.
- TIMEOUT, 1000000: maximum idle cycles between bytes inside a frame (20 ms at 50 MHz).
- TO_W, 20: width of the timeout counter. Must hold TIMEOUT.

Ports:
- clk, in, 1: 50 MHz system clock.
- rst, in, 1: reset.
- rx_rdy, in, 1: 1-cycle pulse; rx_data is valid in the same cycle.
- rx_data, in, 8: received byte.
- core_done, in, 1: pulse from snn_core when the digit is computed.
- ram_addr, out, ADDR_W: input RAM write address.
- ram_wdata, out, 1: pixel bit.
- ram_we, out, 1: input RAM write enable.
- ram_owner, out, 1: 1 means the loader drives the RAM address. The top level muxes ram_addr against the core address using this signal.
- core_start, out, 1: 1-cycle start pulse to snn_core.
- frame_cnt, out, 8: completed-frame counter, wraps at 255 to 0.
- err_timeout, out, 1: 1-cycle pulse when a frame is aborted.
- err_overrun, out, 1: 1-cycle pulse when a byte is dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: every output is 0, state is IDLE, and all counters and the pending buffer are cleared. Reset asserted mid-frame discards all partial progress; RAM contents are left as-is.
- Pixel ordering: byte k, bit i (LSB first) is written to address 8k+i. Addresses run 0..783 with no wrap inside a frame.
- Pending buffer: one byte deep, with a valid flag. A rx_rdy pulse arriving in UNPACK is captured here. If the buffer is already valid, the new byte is dropped and err_overrun pulses.
- IDLE:
  - byte_cnt=0, ram_owner=0.
  - On rx_rdy: latch the byte and go to UNPACK.
- UNPACK:
  - ram_owner=1, ram_we=1 for exactly 8 consecutive cycles, bit_idx 0..7.
  - ram_addr = byte_cnt*8 + bit_idx; ram_wdata = byte[bit_idx].
  - After bit 7, byte_cnt increments.
  - If byte_cnt reaches NUM_BYTES, go to START and discard any pending byte with an err_overrun pulse.
  - Otherwise, if the pending buffer is valid, consume it and stay in UNPACK; the next byte's bit 0 is written in the very next cycle.
  - Otherwise go to RECV.
- RECV:
  - ram_owner=0. The timeout counter increments each cycle and clears on entry.
  - On rx_rdy: latch the byte and go to UNPACK.
  - When the counter reaches TIMEOUT-1 with no byte: pulse err_timeout, go to IDLE, byte_cnt=0.
  - If rx_rdy arrives in the same cycle as the timeout, the byte wins.
- START:
  - core_start=1 for one cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - ram_owner=0. Every rx_rdy is dropped with an err_overrun pulse.
  - On core_done: frame_cnt+1 and go to IDLE.
  - A core_done pulse seen in any other state is ignored.
- Latency:
  - rx_rdy at cycle t gives the first ram_we at t+1.
  - The last bit of byte 97 is written at cycle T; core_start is asserted at T+1.
- The timeout counter is not active in IDLE or WAIT_DONE. An idle line is not an error.

Test Plan:
- Send 98 bytes 0x01, 0x80, 0xFF, 0x00, … spaced 100 cycles apart → writes addr0=1, addr1..7=0, addr8..14=0, addr15=1, addr16..23=1; exactly 784 writes; one core_start one cycle after the addr 783 write; frame_cnt stays 0 until core_done, then becomes 1.
- Two rx_rdy pulses 3 cycles apart (0xA5 then 0x3C) → 16 back-to-back writes with no gap, bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; no err_overrun.
- Three rx_rdy pulses within 8 cycles → third byte dropped and one err_overrun pulse; the first two bytes are written correctly.
- Send 40 bytes, then idle for TIMEOUT cycles → err_timeout pulses once; a fresh 98-byte frame then writes starting at addr 0.
- Bytes sent during WAIT_DONE → one err_overrun per byte, no RAM writes; after core_done, the next frame loads normally.
- Assert rst during byte 50 of a frame → all outputs are 0 the next cycle; a subsequent full frame starts at addr 0; frame_cnt is 0.
